// File: rtl/motoro3_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: ramps step-counter reload and power percent between standstill and target.
// Optional macro M3R_RAMP_DOWN_EN enables the controlled RAMP_DOWN state; otherwise stop aborts like fault.
module motoro3_ramp_ctrl #(
    parameter logic [24:0] START_RELOAD = 25'd1_666_667,
    parameter logic [24:0] MIN_RELOAD   = 25'd16_667,
    parameter logic [24:0] RELOAD_STEP  = 25'd16_667,
    parameter logic [19:0] TICK_CLKS    = 20'd100_000,
    parameter logic [11:0] PWM_LEN      = 12'd512,
    parameter logic [11:0] PWM_MIN_MASK = 12'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        fault,
    input  logic [24:0] cfg_reload,
    input  logic [7:0]  cfg_power,
    output logic [24:0] m3r_step_cnt_reload1,
    output logic [7:0]  m3r_power_percent,
    output logic [11:0] m3r_pwmLenWant,
    output logic [11:0] m3r_pwmMinMask,
    output logic        run_en,
    output logic        at_speed,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] reload_q, reload_d;
    logic [7:0]  power_q, power_d;
    logic [24:0] tgt_reload_q, tgt_reload_d;
    logic [7:0]  tgt_power_q, tgt_power_d;
    logic [19:0] tick_cnt_q, tick_cnt_d;
    logic        run_en_q, run_en_d;
    logic        at_speed_q, at_speed_d;

    logic        is_ramp_s;
    logic        tick_s;
    logic [24:0] clamp_reload_s;
    logic [7:0]  clamp_power_s;
    logic [24:0] up_reload_s;
    logic [8:0]  power_inc_s;
    logic [7:0]  up_power_s;
`ifdef M3R_RAMP_DOWN_EN
    logic [25:0] reload_sum_s;
    logic [24:0] dn_reload_s;
    logic [7:0]  dn_power_s;
`endif

    // Ramp tick detection and per-tick step arithmetic for both directions.
    always_comb begin
        is_ramp_s   = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
        tick_s      = is_ramp_s && (tick_cnt_q == (TICK_CLKS - 20'd1));
        if (cfg_reload < MIN_RELOAD) begin
            clamp_reload_s = MIN_RELOAD;
        end else if (cfg_reload > START_RELOAD) begin
            clamp_reload_s = START_RELOAD;
        end else begin
            clamp_reload_s = cfg_reload;
        end
        clamp_power_s = (cfg_power == 8'd0) ? 8'd1 : cfg_power;
        // A restart from RAMP_DOWN can leave reload below target; treat that as "close enough".
        if ((reload_q <= tgt_reload_q) || ((reload_q - tgt_reload_q) <= RELOAD_STEP)) begin
            up_reload_s = tgt_reload_q;
        end else begin
            up_reload_s = reload_q - RELOAD_STEP;
        end
        power_inc_s = {1'b0, power_q} + 9'd1;
        up_power_s  = (power_inc_s >= {1'b0, tgt_power_q}) ? tgt_power_q : power_inc_s[7:0];
`ifdef M3R_RAMP_DOWN_EN
        reload_sum_s = {1'b0, reload_q} + {1'b0, RELOAD_STEP};
        dn_reload_s  = (reload_sum_s >= {1'b0, START_RELOAD}) ? START_RELOAD : reload_sum_s[24:0];
        dn_power_s   = (power_q == 8'd0) ? 8'd0 : power_q - 8'd1;
`endif
    end

    // Next-state and next-value logic; priority is fault > stop > start > tick.
    always_comb begin
        state_d      = state_q;
        reload_d     = reload_q;
        power_d      = power_q;
        tgt_reload_d = tgt_reload_q;
        tgt_power_d  = tgt_power_q;
        if (fault) begin
            state_d  = IDLE;
            reload_d = START_RELOAD;
            power_d  = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d      = RAMP_UP;
                        tgt_reload_d = clamp_reload_s;
                        tgt_power_d  = clamp_power_s;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RAMP_UP, RUN: begin
                    if (stop) begin
`ifdef M3R_RAMP_DOWN_EN
                        state_d = RAMP_DOWN;
`else
                        state_d  = IDLE;
                        reload_d = START_RELOAD;
                        power_d  = 8'd0;
`endif
                    end else if (tick_s && (state_q == RAMP_UP)) begin
                        reload_d = up_reload_s;
                        power_d  = up_power_s;
                        if ((up_reload_s == tgt_reload_q) && (up_power_s == tgt_power_q)) begin
                            state_d = RUN;
                        end else begin
                            state_d = RAMP_UP;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                RAMP_DOWN: begin
`ifdef M3R_RAMP_DOWN_EN
                    if (start && !stop) begin
                        state_d      = RAMP_UP;
                        tgt_reload_d = clamp_reload_s;
                        tgt_power_d  = clamp_power_s;
                    end else if (tick_s) begin
                        reload_d = dn_reload_s;
                        power_d  = dn_power_s;
                        if ((dn_reload_s == START_RELOAD) && (dn_power_s == 8'd0)) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RAMP_DOWN;
                        end
                    end else begin
                        state_d = RAMP_DOWN;
                    end
`else
                    state_d  = IDLE;
                    reload_d = START_RELOAD;
                    power_d  = 8'd0;
`endif
                end
                default: begin
                    state_d  = IDLE;
                    reload_d = START_RELOAD;
                    power_d  = 8'd0;
                end
            endcase
        end
    end

    // Tick counter restarts on every state change and free-runs only while ramping.
    always_comb begin
        if (state_d != state_q) begin
            tick_cnt_d = 20'd0;
        end else if (is_ramp_s) begin
            tick_cnt_d = tick_s ? 20'd0 : tick_cnt_q + 20'd1;
        end else begin
            tick_cnt_d = 20'd0;
        end
        run_en_d   = (state_d != IDLE);
        at_speed_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            reload_q     <= START_RELOAD;
            power_q      <= 8'd0;
            tgt_reload_q <= START_RELOAD;
            tgt_power_q  <= 8'd0;
            tick_cnt_q   <= 20'd0;
            run_en_q     <= 1'b0;
            at_speed_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            reload_q     <= reload_d;
            power_q      <= power_d;
            tgt_reload_q <= tgt_reload_d;
            tgt_power_q  <= tgt_power_d;
            tick_cnt_q   <= tick_cnt_d;
            run_en_q     <= run_en_d;
            at_speed_q   <= at_speed_d;
        end
    end

    assign m3r_step_cnt_reload1 = reload_q;
    assign m3r_power_percent    = power_q;
    assign m3r_pwmLenWant       = PWM_LEN;
    assign m3r_pwmMinMask       = PWM_MIN_MASK;
    assign run_en               = run_en_q;
    assign at_speed             = at_speed_q;
    assign state_o              = state_q;

endmodule

// File: doc/motoro3_ramp_ctrl.md
Name: motoro3_ramp_ctrl

Overview:
- Soft-start/soft-stop sequencer for the three-phase motor drive.
- Replaces the fixed configuration source for the step counter and PWM blocks.
- On start, ramps the step-count reload from a slow start value down to a target, and the power percent from 0 up to a target, one increment per ramp tick.
- On stop, ramps back down. Fault aborts immediately. The PWM length/mask outputs are static configuration.

Parameters:
- START_RELOAD, 25'd1_666_667, reload at standstill/ramp start (1 Hz electrical at 10 MHz).
- MIN_RELOAD, 25'd16_667, fastest allowed reload; lower targets are clamped to it.
- RELOAD_STEP, 25'd16_667, reload change per ramp tick.
- TICK_CLKS, 20'd100_000, clocks per ramp tick (10 ms at 10 MHz).
- PWM_LEN, 12'd512, value driven on m3r_pwmLenWant.
- PWM_MIN_MASK, 12'd32, value driven on m3r_pwmMinMask.

Ports:
- clk, input, 1, system clock, 10 MHz.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, pulse or level; sampled in IDLE and RAMP_DOWN.
- stop, input, 1, pulse or level; sampled in RAMP_UP and RUN.
- fault, input, 1, immediate abort, any state.
- cfg_reload, input, 25, target reload, latched on start.
- cfg_power, input, 8, target power %, latched on start.
- m3r_step_cnt_reload1, output, 25, current reload to the step counter.
- m3r_power_percent, output, 8, current power %.
- m3r_pwmLenWant, output, 12, constant PWM_LEN.
- m3r_pwmMinMask, output, 12, constant PWM_MIN_MASK.
- run_en, output, 1, motor drive enable.
- at_speed, output, 1, high in RUN only.
- state_o, output, 2, IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - reload=START_RELOAD, power=0, state=IDLE.
  - run_en=0, at_speed=0.
  - tick counter=0, latched targets=START_RELOAD/0.
- All outputs are registered. run_en=1 in RAMP_UP, RUN and RAMP_DOWN.
- Target latch (on IDLE->RAMP_UP or RAMP_DOWN->RAMP_UP):
  - tgt_reload = clamp(cfg_reload, MIN_RELOAD, START_RELOAD).
  - tgt_power = (cfg_power==0) ? 1 : cfg_power.
- Tick counter:
  - Cleared on every state change.
  - Counts 0..TICK_CLKS-1 in RAMP_UP/RAMP_DOWN; tick pulse at TICK_CLKS-1, then wraps to 0.
  - The first tick occurs TICK_CLKS cycles after entering the ramp state.
- Transition priority, per cycle: fault > stop > start > tick.
- IDLE:
  - start -> RAMP_UP next cycle; targets latched.
  - Outputs hold their reset values.
- RAMP_UP, on tick:
  - reload = (reload - tgt_reload <= RELOAD_STEP) ? tgt_reload : reload - RELOAD_STEP. Computed without underflow.
  - power = min(power+1, tgt_power).
  - If, after the update, both equal their targets -> RUN. at_speed rises in the same cycle as state_o==2.
  - stop -> RAMP_DOWN; current values are kept.
- RUN:
  - Holds values. start is ignored.
  - stop -> RAMP_DOWN and at_speed=0.
- RAMP_DOWN, on tick:
  - reload = min(reload+RELOAD_STEP, START_RELOAD), using 26-bit intermediate arithmetic.
  - power = power - 1, saturating at 0.
  - When reload==START_RELOAD and power==0 after the update -> IDLE.
  - start (no stop) -> RAMP_UP, relatching targets; ramping continues from the current values.
- fault, any state:
  - Next cycle: IDLE, reload=START_RELOAD, power=0, run_en=0, at_speed=0.
  - While fault is held, start is ignored.
- Simultaneous start and stop: stop wins; in IDLE, neither has any effect.
- rst asserted mid-ramp: outputs go to reset values asynchronously.

Optional Feature:
- Macro: M3R_RAMP_DOWN_EN.
- Defined: stop behaves as described above (controlled RAMP_DOWN).
- Undefined:
  - The RAMP_DOWN state does not exist. stop acts like fault: next cycle IDLE, reload=START_RELOAD, power=0.
  - state_o never reads 3.

Test Plan:
All cases use START_RELOAD=100, MIN_RELOAD=10, RELOAD_STEP=30, TICK_CLKS=4.
1. Reset release, idle 20 clks -> reload=100, power=0, run_en=0, pwmLenWant=512, pwmMinMask=32.
2. Ramp up:
   - Stimulus: start pulse with cfg_reload=40, cfg_power=3.
   - Response: ticks at +4, +8, +12 clks after RAMP_UP entry.
   - reload 100→70→40→40; power 1→2→3.
   - RUN and at_speed=1 coincide with the third tick.
3. Clamping and zero power: start with cfg_reload=5, cfg_power=0 -> tgt_reload=10, tgt_power=1; reload 70,40,10 then RUN.
4. Ramp down (M3R_RAMP_DOWN_EN defined):
   - Stimulus: stop in RUN from case 2.
   - Response: reload 70→100→100; power 2→1→0.
   - IDLE after the third tick; run_en=0.
   - Undefined build: IDLE one clk after stop.
5. Fault during RAMP_UP after 1 tick -> next clk IDLE, reload=100, power=0. Then start while fault is held -> stays IDLE.
6. Re-start and priority:
   - start during RAMP_DOWN at reload=70, power=2 with cfg_reload=40, cfg_power=2 -> RAMP_UP, reload 40 at the next tick, RUN.
   - start and stop asserted in the same clk in RUN -> RAMP_DOWN.
